// File: rtl/ultrasonic_pkg.sv
// Shared constants and FSM encoding for the ultrasonic ranging path.
package ultrasonic_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CHECK  = 2'd1,
        S_UPDATE = 2'd2,
        S_DECIDE = 2'd3
    } state_t;

    localparam int unsigned DIST_W          = 16;
    localparam int unsigned RANGE_MAX_MM    = 4000;
    localparam int unsigned NEAR_MM_DEFAULT = 150;
    localparam int unsigned FAR_MM_DEFAULT  = 200;

endpackage

// File: rtl/dist_window.sv
// Power-of-two deep sample shift register with a saturating fill counter.
// `oldest` is the entry about to drop out, forced to 0 until the window is full.
module dist_window
    import ultrasonic_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned W          = DIST_W
) (
    input  logic         clk_50M,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic [W-1:0] oldest,
    output logic         full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned FW    = DEPTH_LOG2 + 1;

    logic [W-1:0]  win_q [DEPTH];
    logic [W-1:0]  win_d [DEPTH];
    logic [FW-1:0] fill_q, fill_d;

    assign full   = (fill_q == FW'(DEPTH));
    assign oldest = full ? win_q[DEPTH-1] : '0;

    // Shift a new sample in at the head and bump the fill count until full.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (push) begin
            win_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                win_d[i] = win_q[i-1];
            end
            if (!full) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Window storage and fill counter.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            win_q  <= '{default: '0};
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/ultrasonic_distance_filter.sv
// Periodic sampler, range gate, moving average and debounced hysteretic
// proximity flag for the HC-SR04 distance stream.
module ultrasonic_distance_filter
    import ultrasonic_pkg::*;
#(
    parameter int unsigned SAMPLE_CYCLES = 601000,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned MAX_MM        = RANGE_MAX_MM,
    parameter int unsigned NEAR_MM       = NEAR_MM_DEFAULT,
    parameter int unsigned FAR_MM        = FAR_MM_DEFAULT,
    parameter int unsigned DEBOUNCE      = 3
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic [DIST_W-1:0] distance_in,
    output logic [DIST_W-1:0] dist_avg,
    output logic              avg_valid,
    output logic              near,
    output logic              out_of_range
);

    localparam int unsigned TW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int unsigned SW = DIST_W + AVG_LOG2;
    localparam int unsigned KW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DIST_W-1:0] sample_q, sample_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [DIST_W-1:0] avg_q, avg_d;
    logic              valid_q, valid_d;
    logic              near_q, near_d;
    logic              oor_q, oor_d;
    logic [KW-1:0]     streak_q, streak_d;

    logic              win_push;
    logic [DIST_W-1:0] win_oldest;
    logic              win_full;
    logic [DIST_W-1:0] avg_new;
    logic              qualify;

    dist_window #(
        .DEPTH_LOG2 (AVG_LOG2),
        .W          (DIST_W)
    ) u_window (
        .clk_50M (clk_50M),
        .reset   (reset),
        .push    (win_push),
        .din     (sample_q),
        .oldest  (win_oldest),
        .full    (win_full)
    );

    assign dist_avg     = avg_q;
    assign avg_valid    = valid_q;
    assign near         = near_q;
    assign out_of_range = oor_q;

    // Next-state logic: free-running sample timer, FSM, running sum and hysteresis.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        sum_d    = sum_q;
        avg_d    = avg_q;
        valid_d  = 1'b0;
        near_d   = near_q;
        oor_d    = oor_q;
        streak_d = streak_q;
        win_push = 1'b0;

        timer_d  = (timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);
        avg_new  = DIST_W'(sum_q >> AVG_LOG2);
        qualify  = near_q ? (avg_new >= DIST_W'(FAR_MM)) : (avg_new <= DIST_W'(NEAR_MM));

        case (state_q)
            S_WAIT: begin
                if (timer_q == TIMER_LAST) begin
                    sample_d = distance_in;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (sample_q == '0 || sample_q > DIST_W'(MAX_MM)) begin
                    oor_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    oor_d   = 1'b0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // oldest reads 0 until full, so the sum only ever holds window entries
                win_push = 1'b1;
                sum_d    = sum_q + SW'(sample_q) - SW'(win_oldest);
                state_d  = S_DECIDE;
            end
            S_DECIDE: begin
                state_d = S_WAIT;
                if (win_full) begin
                    avg_d   = avg_new;
                    valid_d = 1'b1;
                    if (qualify) begin
                        if (streak_q + KW'(1) == KW'(DEBOUNCE)) begin
                            near_d   = ~near_q;
                            streak_d = '0;
                        end else begin
                            streak_d = streak_q + KW'(1);
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q  <= S_WAIT;
            timer_q  <= '0;
            sample_q <= '0;
            sum_q    <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
            near_q   <= 1'b0;
            oor_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sample_q <= sample_d;
            sum_q    <= sum_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            near_q   <= near_d;
            oor_q    <= oor_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: doc/ultrasonic_distance_filter.md
# ultrasonic_distance_filter

Downstream consumer of the HC-SR04 ranging stage. Samples that stage's continuously updated 16-bit millimetre distance once per measurement period and rejects out-of-range readings. Computes a power-of-two moving average and drives a debounced, hysteretic `near` flag for the control logic.

## Interface
Parameters:
- `SAMPLE_CYCLES`, 601000: clocks between samples, one ranging period at 50 MHz.
- `AVG_LOG2`, 2: log2 of the averaging window; the window holds 4 samples.
- `MAX_MM`, 4000: largest accepted reading in mm.
- `NEAR_MM`, 150: `near` is set when avg ≤ this value.
- `FAR_MM`, 200: `near` is cleared when avg ≥ this value. Must be > `NEAR_MM`.
- `DEBOUNCE`, 3: number of consecutive qualifying averages needed to change `near`.

Ports:
- `clk_50M`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `distance_in`  in  16  distance from the ranging stage, in mm.
- `dist_avg`  out  16  latest window average in mm. Registered.
- `avg_valid`  out  1  one-cycle pulse when `dist_avg` updates.
- `near`  out  1  debounced proximity flag.
- `out_of_range`  out  1  high while the last sample was rejected.

## Operation
- Reset values:
  - All outputs 0.
  - Timer, window, sum, fill count and streak counter 0.
  - State `S_WAIT`.
- Reset acts immediately at any point, including mid-operation. After reset, the window must refill before the next `avg_valid`.
- FSM:
  - `S_WAIT`: timer counts 0…`SAMPLE_CYCLES`-1. At the terminal count, `distance_in` is latched into `sample`, the timer returns to 0, and the FSM goes to `S_CHECK`. The timer free-runs in all states, so the sample spacing is exactly `SAMPLE_CYCLES`.
  - `S_CHECK`:
    - If `sample`==0 or `sample`>`MAX_MM`: set `out_of_range`=1, go to `S_WAIT`. Window, sum and streak are untouched.
    - Otherwise: set `out_of_range`=0, go to `S_UPDATE`.
  - `S_UPDATE`:
    - Shift `sample` into the window.
    - `sum <= sum + sample - oldest`, where `oldest` is 0 while the window is not yet full.
    - Fill count increments, saturating at 2^`AVG_LOG2`.
    - Go to `S_DECIDE`.
  - `S_DECIDE`:
    - If the window is not full: go to `S_WAIT`, no pulse.
    - Otherwise: `dist_avg <= sum >> AVG_LOG2` (truncating, floor), pulse `avg_valid`, run the hysteresis step, go to `S_WAIT`.
- Arithmetic:
  - `sum` is 16+`AVG_LOG2` bits and cannot overflow.
  - The subtraction is done at full sum width and never goes negative.
- Hysteresis step, using the new average `a`:
  - If `near`=0 and `a`≤`NEAR_MM`: streak++. Otherwise streak=0.
  - If `near`=1 and `a`≥`FAR_MM`: streak++. Otherwise streak=0.
  - When streak reaches `DEBOUNCE`: toggle `near`, streak=0.
  - Averages strictly between `NEAR_MM` and `FAR_MM` reset the streak and never change `near`.
- Rejected samples neither break nor advance the streak.

## Timing
- Sample latched on clock edge T. `avg_valid` is high in cycle T+3, and `dist_avg` and `near` are valid from T+3.
- `out_of_range` updates at T+1 and holds until the next `S_CHECK`.
- No input handshake: `distance_in` is treated as quasi-static, which the ranging stage guarantees between updates.
- First `avg_valid` after reset: after the 4th accepted sample, i.e. no earlier than 4·`SAMPLE_CYCLES`+3 cycles.

## Structure
- Package `ultrasonic_pkg` holds:
  - state encoding `S_WAIT`/`S_CHECK`/`S_UPDATE`/`S_DECIDE`;
  - `MAX_MM` and the default `NEAR_MM`/`FAR_MM`.
  - The ranging stage shares the mm constants.
- Sub-module `dist_window`: a 2^`AVG_LOG2`-deep shift register plus fill counter.
  - Inputs: `push`, `din`.
  - Outputs: `oldest`, `full`.
  - Same clock and reset.
- Top level: FSM, timer, sum, hysteresis.

## Test plan
Test plan runs with `SAMPLE_CYCLES`=10.
- **Reset:** assert `reset`=0 mid-`S_UPDATE` → all outputs 0 within the same cycle. Then four samples of 1000 are needed before `avg_valid`.
- **Steady input:** `distance_in`=1000 constant → first `avg_valid` at 4·10+3 cycles after reset release with `dist_avg`=1000 and `near`=0, then a pulse every 10 cycles.
- **Averaging and floor:**
  - Samples 100, 200, 300, 400 → `dist_avg`=250.
  - Next sample 101 → (200+300+400+101)>>2 = 250.
  - Samples 100, 100, 100, 101 → 100.
- **Rejection:**
  - Sample 0 → `out_of_range`=1, no `avg_valid`, window unchanged.
  - Sample 4001 → same behaviour.
  - Sample 4000 → accepted, `out_of_range`=0.
- **Hysteresis:**
  - Averages 140, 140, 140 → `near`=1 on the third `avg_valid`.
  - Averages 170 ×5 → `near` stays 1.
  - Averages 200, 200, 170, 200, 200, 200 → `near`=0 only on the last one (the 170 resets the streak).
- **Rejection does not break streak:** averages 140, 140, then a rejected sample, then 140 → `near`=1 on that final 140.
